// File: rtl/press_pkg.sv
// Shared types and default timing constants for the press classifier.
// State encodings are fixed so that the state register can be probed directly.
package press_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam int TICK_BITS_DEF  = 20;
  localparam int CNT_W_DEF      = 8;
  localparam int LONG_TICKS_DEF = 100;
  localparam int DCLK_TICKS_DEF = 30;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler that fires a one-cycle tick every 2^TICK_BITS clocks.
// A synchronous clear realigns the tick phase to the most recent db edge.
module tick_gen #(
  parameter int TICK_BITS = press_pkg::TICK_BITS_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  logic [TICK_BITS-1:0] presc_q;
  logic [TICK_BITS-1:0] presc_d;

  always_comb begin
    presc_d = clr ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = &presc_q;

endmodule

// File: rtl/press_classifier.sv
// Times debounced presses in prescaled ticks and classifies them as short,
// long or double, emitting a registered one-cycle pulse per classification.
module press_classifier
  import press_pkg::*;
#(
  parameter int TICK_BITS  = TICK_BITS_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int DCLK_TICKS = DCLK_TICKS_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             db,
  output logic             short_tick,
  output logic             long_tick,
  output logic             dbl_tick,
  output logic             busy,
  output logic [CNT_W-1:0] press_len
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLK_LAST = CNT_W'(DCLK_TICKS - 1);

  logic             db_q;
  logic             rise, fall, edge_ev, tick;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d, cnt_inc;
  state_e           state_q, state_d;
  logic             short_q, short_d, long_q, long_d, dbl_q, dbl_d, busy_q, busy_d;
  logic [CNT_W-1:0] press_len_q, press_len_d;

  assign rise    = db & ~db_q;
  assign fall    = ~db & db_q;
  assign edge_ev = rise | fall;

  tick_gen #(.TICK_BITS(TICK_BITS)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (edge_ev),
    .tick    (tick)
  );

  // cnt_inc includes a tick landing on the release cycle, so press_len
  // counts every tick boundary crossed up to and including the release edge.
  always_comb begin
    cnt_inc = tick_cnt_q;
    if (tick && (tick_cnt_q != '1)) begin
      cnt_inc = tick_cnt_q + 1'b1;
    end
    tick_cnt_d = edge_ev ? '0 : cnt_inc;
  end

  // Edges are tested before terminal ticks so release/new-press always win.
  always_comb begin
    state_d     = state_q;
    press_len_d = press_len_q;
    short_d     = 1'b0;
    long_d      = 1'b0;
    dbl_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (fall) begin
          state_d     = ST_GAP;
          press_len_d = cnt_inc;
        end else if (tick && (tick_cnt_q == LONG_LAST)) begin
          state_d = ST_HOLD;
          long_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (rise) begin
          state_d = ST_PRESS2;
        end else if (tick && (tick_cnt_q == DCLK_LAST)) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          state_d     = ST_IDLE;
          dbl_d       = 1'b1;
          press_len_d = cnt_inc;
        end else if (tick && (tick_cnt_q == LONG_LAST)) begin
          state_d = ST_HOLD;
          dbl_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (fall) begin
          state_d     = ST_IDLE;
          press_len_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q        <= 1'b0;
      tick_cnt_q  <= '0;
      state_q     <= ST_IDLE;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      dbl_q       <= 1'b0;
      busy_q      <= 1'b0;
      press_len_q <= '0;
    end else begin
      db_q        <= db;
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      short_q     <= short_d;
      long_q      <= long_d;
      dbl_q       <= dbl_d;
      busy_q      <= busy_d;
      press_len_q <= press_len_d;
    end
  end

  assign short_tick = short_q;
  assign long_tick  = long_q;
  assign dbl_tick   = dbl_q;
  assign busy       = busy_q;
  assign press_len  = press_len_q;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with a fast tick (TICK_BITS=2, CNT_W=4).
// Times are expressed relative to E, the edge that first samples db high.
module tb_press_classifier;

  logic       clk;
  logic       reset_n;
  logic       db;
  logic       short_tick, long_tick, dbl_tick, busy;
  logic [3:0] press_len;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int n_short = 0, n_long = 0, n_dbl = 0, n_multi = 0;
  int s0, l0, d0, m0;
  int e, f;

  press_classifier #(
    .TICK_BITS  (2),
    .CNT_W      (4),
    .LONG_TICKS (3),
    .DCLK_TICKS (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .db         (db),
    .short_tick (short_tick),
    .long_tick  (long_tick),
    .dbl_tick   (dbl_tick),
    .busy       (busy),
    .press_len  (press_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (short_tick === 1'b1) n_short <= n_short + 1;
    if (long_tick === 1'b1)  n_long  <= n_long + 1;
    if (dbl_tick === 1'b1)   n_dbl   <= n_dbl + 1;
    if ((32'(short_tick) + 32'(long_tick) + 32'(dbl_tick)) > 1) n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-18s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advances to 1 time unit after posedge number t.
  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    s0 = n_short; l0 = n_long; d0 = n_dbl; m0 = n_multi;
  endtask

  initial begin
    reset_n = 1'b0;
    db      = 1'b0;
    goto(3);
    chk("rst_short", 32'(short_tick), 0);
    chk("rst_long",  32'(long_tick), 0);
    chk("rst_dbl",   32'(dbl_tick), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_len",   32'(press_len), 0);
    reset_n = 1'b1;
    goto(6);

    // Short press: high 5 cycles
    snap();
    db = 1'b1; e = cyc + 1;
    goto(e);      chk("sp_busy_on", 32'(busy), 1);
    goto(e + 4);  db = 1'b0;
    goto(e + 5);  chk("sp_len", 32'(press_len), 1);
                  chk("sp_busy_gap", 32'(busy), 1);
    goto(e + 12); chk("sp_short_early", 32'(short_tick), 0);
    goto(e + 13); chk("sp_short", 32'(short_tick), 1);
                  chk("sp_busy_off", 32'(busy), 0);
    goto(e + 14); chk("sp_short_after", 32'(short_tick), 0);
    goto(e + 25);
    chk("sp_cnt_short", 32'(n_short - s0), 1);
    chk("sp_cnt_other", 32'(n_long - l0 + n_dbl - d0), 0);

    // Long press: high 20 cycles
    snap();
    db = 1'b1; e = cyc + 1;
    goto(e + 11); chk("lp_long_early", 32'(long_tick), 0);
    goto(e + 12); chk("lp_long", 32'(long_tick), 1);
                  chk("lp_busy", 32'(busy), 1);
    goto(e + 13); chk("lp_long_after", 32'(long_tick), 0);
    goto(e + 19); db = 1'b0;
    goto(e + 20); chk("lp_len", 32'(press_len), 5);
                  chk("lp_busy_off", 32'(busy), 0);
                  chk("lp_no_pulse", 32'(short_tick) + 32'(long_tick) + 32'(dbl_tick), 0);
    goto(e + 40);
    chk("lp_cnt_long", 32'(n_long - l0), 1);
    chk("lp_cnt_other", 32'(n_short - s0 + n_dbl - d0), 0);

    // Double press: high 5, low 3, high 5
    snap();
    db = 1'b1; e = cyc + 1;
    goto(e + 4);  db = 1'b0;
    goto(e + 7);  db = 1'b1;
    goto(e + 12); db = 1'b0;
                  chk("dp_dbl_early", 32'(dbl_tick), 0);
    goto(e + 13); chk("dp_dbl", 32'(dbl_tick), 1);
                  chk("dp_len", 32'(press_len), 1);
                  chk("dp_busy_off", 32'(busy), 0);
    goto(e + 14); chk("dp_dbl_after", 32'(dbl_tick), 0);
    goto(e + 40);
    chk("dp_cnt_dbl", 32'(n_dbl - d0), 1);
    chk("dp_cnt_short", 32'(n_short - s0), 0);

    // Gap-expiry collision: second rise sampled exactly at F+8
    snap();
    db = 1'b1; e = cyc + 1; f = e + 5;
    goto(e + 4);  db = 1'b0;
    goto(f + 7);  db = 1'b1;
    goto(f + 8);  chk("col_short", 32'(short_tick), 0);
                  chk("col_busy", 32'(busy), 1);
    goto(f + 10); db = 1'b0;
    goto(f + 11); chk("col_dbl", 32'(dbl_tick), 1);
                  chk("col_len", 32'(press_len), 0);
    goto(f + 40);
    chk("col_cnt_short", 32'(n_short - s0), 0);
    chk("col_cnt_dbl", 32'(n_dbl - d0), 1);

    // Saturation: high 100 cycles
    snap();
    db = 1'b1; e = cyc + 1;
    goto(e + 99);  db = 1'b0;
    goto(e + 100); chk("sat_len", 32'(press_len), 15);
                   chk("sat_busy_off", 32'(busy), 0);
    goto(e + 120);
    chk("sat_cnt_long", 32'(n_long - l0), 1);
    chk("sat_cnt_other", 32'(n_short - s0 + n_dbl - d0), 0);

    // Reset mid-press with db held high
    db = 1'b1; e = cyc + 1;
    goto(e + 6);
    reset_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_len", 32'(press_len), 0);
    chk("mr_pulses", 32'(short_tick) + 32'(long_tick) + 32'(dbl_tick), 0);
    goto(e + 8);
    chk("mr_len_hold", 32'(press_len), 0);
    reset_n = 1'b1;
    snap();
    goto(cyc + 6);
    chk("mr_no_pulse", 32'(n_short - s0 + n_long - l0 + n_dbl - d0), 0);
    db = 1'b0;
    goto(cyc + 30);

    // Fresh short press after reset recovery
    snap();
    db = 1'b1; e = cyc + 1;
    goto(e + 4);  db = 1'b0;
    goto(e + 13); chk("pr_short", 32'(short_tick), 1);
                  chk("pr_len", 32'(press_len), 1);
    goto(e + 20);
    chk("pr_cnt_short", 32'(n_short - s0), 1);

    chk("one_hot", 32'(n_multi), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
